// File: rtl/bcd_to_bin_decoder.sv
// bcd_to_bin_decoder
//   Collects a multi-digit BCD number, most significant digit first, one digit
//   per valid/ready transfer, and presents its binary value on a valid/ready
//   result port. Also keeps a registered one-hot decimal decode of the most
//   recently accepted digit.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     digit stream handshake
//   in_digit              BCD digit (10-15 flagged as illegal, counted as 0)
//   in_last               least significant digit of the frame
//   out_valid/out_ready   result handshake
//   out_value             binary value of the frame
//   out_ndig              number of digits accepted in the frame
//   out_err               bit0 illegal digit, bit1 length overrun
//   dig_onehot            one-hot decimal of last accepted digit
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_COLLECT | accepting digits, accumulating value; result outputs are zero
// S_HOLD    | result presented and frozen until the consumer takes it

module bcd_to_bin_decoder #(
   parameter int NDIG  = 4,
   parameter int OUT_W = 14,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_digit,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_value,
   output logic [CNT_W-1:0] out_ndig,
   output logic [1:0]       out_err,
   output logic [9:0]       dig_onehot
);

   typedef enum logic {S_COLLECT = 1'b0, S_HOLD = 1'b1} state_t;

   state_t           r_state;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [OUT_W-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_err;
   logic [OUT_W-1:0] r_out_value;
   logic [CNT_W-1:0] r_out_ndig;
   logic [1:0]       r_out_err;
   logic [9:0]       r_onehot;

   logic             w_accept;
   logic             w_dig_ok;
   logic [3:0]       w_dig;
   logic [OUT_W+3:0] w_acc_wide;
   logic [OUT_W-1:0] w_acc_next;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_overrun;
   logic [1:0]       w_err_next;
   logic [9:0]       w_onehot_next;

   assign w_accept   = in_valid && r_in_ready;
   assign w_dig_ok   = (in_digit <= 4'd9);
   assign w_dig      = w_dig_ok ? in_digit : 4'd0;

   // acc*10 + d computed as (acc<<3)+(acc<<1)+d with 4 bits of headroom
   assign w_acc_wide = ({4'b0000, r_acc} << 3) + ({4'b0000, r_acc} << 1)
                       + {{OUT_W{1'b0}}, w_dig};
   assign w_acc_next = w_acc_wide[OUT_W-1:0];
   assign w_cnt_next = r_cnt + 1'b1;

   // Reaching NDIG digits without in_last closes the frame as an overrun
   assign w_overrun  = (w_cnt_next == CNT_W'(NDIG)) && !in_last;
   assign w_err_next = {r_err[1] | w_overrun, r_err[0] | ~w_dig_ok};

   assign w_onehot_next = w_dig_ok ? (10'd1 << in_digit) : 10'd0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_COLLECT;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_err       <= '0;
         r_out_value <= '0;
         r_out_ndig  <= '0;
         r_out_err   <= '0;
         r_onehot    <= '0;
      end else begin
         case (r_state)
            S_COLLECT: begin
               if (w_accept) begin
                  r_acc    <= w_acc_next;
                  r_cnt    <= w_cnt_next;
                  r_err    <= w_err_next;
                  r_onehot <= w_onehot_next;
                  if (in_last || w_overrun) begin
                     r_state     <= S_HOLD;
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_out_value <= w_acc_next;
                     r_out_ndig  <= w_cnt_next;
                     r_out_err   <= w_err_next;
                  end
               end
            end
            S_HOLD: begin
               if (r_out_valid && out_ready) begin
                  r_state     <= S_COLLECT;
                  r_in_ready  <= 1'b1;
                  r_out_valid <= 1'b0;
                  r_acc       <= '0;
                  r_cnt       <= '0;
                  r_err       <= '0;
                  r_out_value <= '0;
                  r_out_ndig  <= '0;
                  r_out_err   <= '0;
               end
            end
            default: begin
               r_state     <= S_COLLECT;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready   = r_in_ready;
   assign out_valid  = r_out_valid;
   assign out_value  = r_out_value;
   assign out_ndig   = r_out_ndig;
   assign out_err    = r_out_err;
   assign dig_onehot = r_onehot;

endmodule

// File: tb/tb_bcd_to_bin_decoder.sv
// Directed bench for bcd_to_bin_decoder with hand-computed expectations.

module tb_bcd_to_bin_decoder;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_digit;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [13:0] out_value;
   logic [2:0]  out_ndig;
   logic [1:0]  out_err;
   logic [9:0]  dig_onehot;

   int n_checks;
   int n_fail;

   bcd_to_bin_decoder #(.NDIG(4), .OUT_W(14), .CNT_W(3)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_digit   (in_digit),
      .in_last    (in_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_value  (out_value),
      .out_ndig   (out_ndig),
      .out_err    (out_err),
      .dig_onehot (dig_onehot)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // one clock edge; inputs settle and outputs are sampled 1ns after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] d, input logic last);
      in_valid = 1'b1;
      in_digit = d;
      in_last  = last;
      step();
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_digit = 4'd0;
      in_last  = 1'b0;
   endtask

   task automatic chk_result(input string tag, input int val, input int nd, input int er);
      chk({tag, ".valid"}, 32'(out_valid), 1);
      chk({tag, ".ready"}, 32'(in_ready), 0);
      chk({tag, ".value"}, 32'(out_value), val);
      chk({tag, ".ndig"},  32'(out_ndig), nd);
      chk({tag, ".err"},   32'(out_err), er);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".valid"}, 32'(out_valid), 0);
      chk({tag, ".ready"}, 32'(in_ready), 1);
      chk({tag, ".value"}, 32'(out_value), 0);
      chk({tag, ".ndig"},  32'(out_ndig), 0);
      chk({tag, ".err"},   32'(out_err), 0);
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst       = 1'b1;
      out_ready = 1'b0;
      idle();
      step();
      step();
      rst = 1'b0;
      chk_idle("reset");
      chk("reset.onehot", 32'(dig_onehot), 0);

      // 1,2,3,4 -> 1234
      out_ready = 1'b1;
      send(4'd1, 1'b0);
      chk("t1.collect_value", 32'(out_value), 0);
      chk("t1.onehot1", 32'(dig_onehot), 2);
      send(4'd2, 1'b0);
      send(4'd3, 1'b0);
      send(4'd4, 1'b1);
      idle();
      chk_result("t1", 1234, 4, 0);
      chk("t1.onehot", 32'(dig_onehot), 16);
      step();
      chk_idle("t1.after");

      // 5, illegal 0xA -> 50 with err bit0
      send(4'd5, 1'b0);
      send(4'hA, 1'b1);
      idle();
      chk_result("t2", 50, 2, 1);
      chk("t2.onehot", 32'(dig_onehot), 0);
      step();
      chk_idle("t2.after");

      // 9,9,9,9 without in_last -> overrun
      send(4'd9, 1'b0);
      send(4'd9, 1'b0);
      send(4'd9, 1'b0);
      out_ready = 1'b0;
      send(4'd9, 1'b0);
      chk_result("t3", 9999, 4, 2);
      in_valid = 1'b1;
      in_digit = 4'd5;
      step();
      step();
      chk_result("t3.no5th", 9999, 4, 2);
      chk("t3.onehot", 32'(dig_onehot), 512);
      idle();
      out_ready = 1'b1;
      step();
      chk_idle("t3.after");
      chk("t3.onehot_kept", 32'(dig_onehot), 512);

      // 7 held under backpressure while digit 3 is offered
      out_ready = 1'b0;
      send(4'd7, 1'b1);
      in_valid = 1'b1;
      in_digit = 4'd3;
      in_last  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk_result("t4.hold", 7, 1, 0);
         chk("t4.onehot", 32'(dig_onehot), 128);
         step();
      end
      out_ready = 1'b1;
      step();
      chk_idle("t4.handshake");
      step();
      idle();
      chk_result("t4.new", 3, 1, 0);
      chk("t4.onehot3", 32'(dig_onehot), 8);
      step();
      chk_idle("t4.after");

      // reset mid-frame
      send(4'd4, 1'b0);
      send(4'd2, 1'b0);
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_idle("t5.reset");
      chk("t5.onehot", 32'(dig_onehot), 0);
      send(4'd6, 1'b1);
      idle();
      chk_result("t5", 6, 1, 0);
      step();
      chk_idle("t5.after");

      // single digit 0
      send(4'd0, 1'b1);
      idle();
      chk_result("t6", 0, 1, 0);
      chk("t6.onehot", 32'(dig_onehot), 1);
      step();
      chk_idle("t6.after");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_to_bin_decoder.md
Name: bcd_to_bin_decoder

Overview:
Sequential decoder for the decimal-to-BCD path. It accepts a multi-digit BCD number one digit per transfer, most significant digit first, over a valid/ready stream. It accumulates the binary value and presents it on a valid/ready result port. It also exposes a registered one-hot decimal decode of the most recently accepted digit, which is the inverse of the decimal encoder. It sits between BCD producers (keypad/encoder logic) and binary arithmetic consumers.

Parameters:
NDIG, 4, maximum digits per frame (>=1)
OUT_W, 14, result width; must satisfy 2^OUT_W > 10^NDIG - 1 (14 covers 9999)
CNT_W, 3, digit-counter width; must hold NDIG

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  digit offered
in_ready  output  1  block can accept a digit
in_digit  input  4  BCD digit; 0-9 legal, 10-15 illegal
in_last  input  1  digit is the least significant of the frame
out_valid  output  1  result held
out_ready  input  1  consumer takes result
out_value  output  OUT_W  binary value of frame
out_ndig  output  CNT_W  digits accepted in frame
out_err  output  2  bit0 illegal digit seen; bit1 length overrun (NDIG digits without in_last)
dig_onehot  output  10  one-hot decimal of last accepted digit

Behaviour:
- One clock. Reset is synchronous and active-high, and it dominates every other input on the same edge.
- Reset values: state=COLLECT, in_ready=1, out_valid=0, out_value=0, out_ndig=0, out_err=00, dig_onehot=0.
- Two states: COLLECT and HOLD.
- COLLECT:
  - in_ready=1 and out_valid=0.
  - A digit is accepted when in_valid and in_ready are both 1 at a clock edge.
  - On accept: acc <= acc*10 + d, where d=in_digit if in_digit<=9, else d=0 and err[0] is set (sticky within the frame). count <= count+1.
  - Arithmetic is done at OUT_W+4 bits and truncated to OUT_W. No truncation occurs within the parameter constraint.
  - dig_onehot <= (1 << in_digit) if in_digit<=9, else 10'b0. The register holds between accepts and across frames.
  - Go to HOLD if in_last=1.
  - Also go to HOLD if count+1 == NDIG with in_last=0; set err[1] in that case.
  - If in_last=1 on the NDIG-th digit, err[1] stays 0.
- HOLD:
  - in_ready=0 and out_valid=1.
  - out_value, out_ndig and out_err are stable. in_valid is ignored.
  - When out_valid and out_ready are both 1, go to COLLECT and clear acc, count and err. out_value, out_ndig and out_err also return to 0.
- Latency: the result is valid on the cycle after the edge that accepts the final digit.
- Throughput: at least one bubble per frame. in_ready stays 0 during the HOLD-exit cycle, so the next frame's first digit is accepted one edge after the result handshake.
- out_value, out_ndig and out_err are registered and reflect the frame only while out_valid=1. They are 0 in COLLECT.
- out_valid never deasserts without the handshake, except on reset.
- Reset mid-frame or during HOLD discards the partial or held result and returns to the reset values.
- A frame of a single digit with in_last=1 is legal and gives out_ndig=1.

Test Plan:
- Digits 1,2,3,4 on consecutive cycles, in_last on 4, out_ready=1 -> out_valid the cycle after the 4th accept, out_value=1234, out_ndig=4, out_err=00, dig_onehot=10'b0000010000. Next cycle: out_valid=0, in_ready=1.
- Digits 5, then 0xA with in_last -> out_value=50, out_ndig=2, out_err=01, dig_onehot=0.
- NDIG=4, digits 9,9,9,9 with in_last never asserted -> HOLD after the 4th digit, out_value=9999 (14'h270F), out_err=10. A 5th in_valid is not accepted.
- Frame 7 with in_last, out_ready low for 3 cycles while in_valid=1, in_digit=3 -> out_valid and out_value=7 held for 3 cycles, in_ready=0, digit 3 not accepted. Raise out_ready -> handshake, then 3 is accepted as a new frame.
- Digits 4,2, then rst for 1 cycle, then digit 6 with in_last -> all outputs at reset values after rst; result out_value=6, out_ndig=1, out_err=00.
- Single digit 0 with in_last -> out_value=0, out_ndig=1, dig_onehot=10'b0000000001.
